// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - in-order write-back FIFO draining into the register file write port
// Also forwards queued results to the two decode read ports, newest entry first.
module regfile_wb_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     we,
  output logic [ADDR_W-1:0]        waddr,
  output logic [DATA_W-1:0]        wdata,
  input  logic [ADDR_W-1:0]        fw_raddr1,
  output logic                     fw_hit1,
  output logic [DATA_W-1:0]        fw_data1,
  input  logic [ADDR_W-1:0]        fw_raddr2,
  output logic                     fw_hit2,
  output logic [DATA_W-1:0]        fw_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  fw_idx;
  logic              push;
  logic              pop;

  assign in_ready = rst && (count < CNT_W'(DEPTH));
  // r0 writes finish the handshake but never occupy a slot
  assign push     = in_valid && in_ready && (in_addr != '0);
  assign pop      = (count != '0);
  assign idle     = (count == '0) && !we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= in_addr;
      mem_data[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      we <= pop;
      if (pop) begin
        waddr <= mem_addr[rd_ptr];
        wdata <= mem_data[rd_ptr];
      end
    end
  end

  // Scan oldest to newest so later matches override; the output register ranks lowest.
  always_comb begin
    fw_hit1  = 1'b0;
    fw_data1 = '0;
    fw_hit2  = 1'b0;
    fw_data2 = '0;
    fw_idx   = '0;
    if (we && (waddr == fw_raddr1)) begin
      fw_hit1  = 1'b1;
      fw_data1 = wdata;
    end
    if (we && (waddr == fw_raddr2)) begin
      fw_hit2  = 1'b1;
      fw_data2 = wdata;
    end
    for (int i = 0; i < DEPTH; i++) begin
      fw_idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        if (mem_addr[fw_idx] == fw_raddr1) begin
          fw_hit1  = 1'b1;
          fw_data1 = mem_data[fw_idx];
        end
        if (mem_addr[fw_idx] == fw_raddr2) begin
          fw_hit2  = 1'b1;
          fw_data2 = mem_data[fw_idx];
        end
      end
    end
    if (fw_raddr1 == '0) begin
      fw_hit1  = 1'b0;
      fw_data1 = '0;
    end
    if (fw_raddr2 == '0) begin
      fw_hit2  = 1'b0;
      fw_data2 = '0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - randomized self-checking bench for regfile_wb_queue
module tb_regfile_wb_queue;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] fw_raddr1 = '0;
  logic              fw_hit1;
  logic [DATA_W-1:0] fw_data1;
  logic [ADDR_W-1:0] fw_raddr2 = '0;
  logic              fw_hit2;
  logic [DATA_W-1:0] fw_data2;
  logic [CNT_W-1:0]  count;
  logic              idle;

  always #5 clk = ~clk;

  regfile_wb_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .we(we), .waddr(waddr), .wdata(wdata),
    .fw_raddr1(fw_raddr1), .fw_hit1(fw_hit1), .fw_data1(fw_data1),
    .fw_raddr2(fw_raddr2), .fw_hit2(fw_hit2), .fw_data2(fw_data2),
    .count(count), .idle(idle)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: pending writes as a queue plus the last write presented to the register file
  logic [ADDR_W-1:0] mq_addr[$];
  logic [DATA_W-1:0] mq_data[$];
  logic              m_we = 1'b0;
  logic [ADDR_W-1:0] m_waddr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  bit                last_acc;

  task automatic tick();
    bit acc;
    acc = in_valid && rst && (mq_addr.size() < DEPTH);
    @(posedge clk);
    if (mq_addr.size() > 0) begin
      m_we = 1'b1;
      m_waddr = mq_addr.pop_front();
      m_wdata = mq_data.pop_front();
    end else begin
      m_we = 1'b0;
    end
    if (acc && in_addr != '0) begin
      mq_addr.push_back(in_addr);
      mq_data.push_back(in_data);
    end
    last_acc = acc;
    #1;
  endtask

  function automatic void model_fw(input logic [ADDR_W-1:0] ra, output logic hit, output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d = '0;
    if (ra == '0) return;
    for (int i = mq_addr.size() - 1; i >= 0; i--) begin
      if (mq_addr[i] == ra) begin
        hit = 1'b1;
        d = mq_data[i];
        return;
      end
    end
    if (m_we && m_waddr == ra) begin
      hit = 1'b1;
      d = m_wdata;
    end
  endfunction

  task automatic model_reset();
    rst = 1'b0;
    mq_addr.delete();
    mq_data.delete();
    m_we = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  task automatic test_reset();
    model_reset();
    fw_raddr1 = 5'd9;
    fw_raddr2 = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", we); end
    checks++; if (count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%0b exp=1", idle); end
    checks++; if (fw_hit1 !== 1'b0 || fw_data1 !== '0) begin failures++; $display("FAIL reset_fw1 got=%0b/%h exp=0/0", fw_hit1, fw_data1); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_write();
    in_valid = 1'b1; in_addr = 5'd5; in_data = 32'hDEADBEEF; fw_raddr1 = 5'd5;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%0b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (count !== CNT_W'(1) || we !== 1'b0) begin failures++; $display("FAIL single_edge1 count=%0d we=%0b exp=1/0", count, we); end
    checks++; if (fw_hit1 !== 1'b1 || fw_data1 !== 32'hDEADBEEF) begin failures++; $display("FAIL single_fw got=%0b/%h exp=1/deadbeef", fw_hit1, fw_data1); end
    tick();
    checks++; if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_write got=%0b/%0d/%h exp=1/5/deadbeef", we, waddr, wdata); end
    tick();
    checks++; if (we !== 1'b0 || idle !== 1'b1 || waddr !== 5'd5) begin failures++; $display("FAIL single_done we=%0b idle=%0b waddr=%0d exp=0/1/5", we, idle, waddr); end
  endtask

  task automatic test_r0();
    in_valid = 1'b1; in_addr = 5'd0; in_data = 32'h1234; fw_raddr1 = 5'd0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL r0_ready got=%0b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (count !== '0 || fw_hit1 !== 1'b0) begin failures++; $display("FAIL r0_enqueue count=%0d hit=%0b exp=0/0", count, fw_hit1); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (we !== 1'b0) begin failures++; $display("FAIL r0_we cycle=%0d got=%0b exp=0", i, we); end
    end
  endtask

  task automatic test_forward();
    fw_raddr1 = 5'd7; fw_raddr2 = 5'd7;
    in_valid = 1'b1; in_addr = 5'd7; in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (fw_hit1 !== 1'b1 || fw_data1 !== 32'h22) begin failures++; $display("FAIL fwd_newest got=%0b/%h exp=1/22", fw_hit1, fw_data1); end
    checks++; if (fw_hit2 !== 1'b1 || fw_data2 !== 32'h22) begin failures++; $display("FAIL fwd_newest2 got=%0b/%h exp=1/22", fw_hit2, fw_data2); end
    checks++; if (we !== 1'b1 || wdata !== 32'h11) begin failures++; $display("FAIL fwd_first_write got=%0b/%h exp=1/11", we, wdata); end
    tick();
    checks++; if (fw_hit1 !== 1'b1 || fw_data1 !== 32'h22 || wdata !== 32'h22) begin failures++; $display("FAIL fwd_outreg got=%0b/%h wdata=%h exp=1/22/22", fw_hit1, fw_data1, wdata); end
    tick();
    checks++; if (fw_hit1 !== 1'b0 || fw_data1 !== '0) begin failures++; $display("FAIL fwd_drained got=%0b/%h exp=0/0", fw_hit1, fw_data1); end
  endtask

  task automatic test_fill();
    logic [DATA_W-1:0] vals [6];
    int sent = 0, got = 0, cyc = 0;
    bit started = 0;
    for (int i = 0; i < 6; i++) vals[i] = $urandom;
    while (got < 6 && cyc < 40) begin
      in_valid = (sent < 6);
      in_addr = ADDR_W'(sent + 1);
      in_data = vals[sent < 6 ? sent : 0];
      #1;
      checks++; if (in_ready !== (mq_addr.size() < DEPTH)) begin failures++; $display("FAIL fill_ready got=%0b count=%0d", in_ready, count); end
      tick();
      if (last_acc && sent < 6) sent++;
      if (we === 1'b1) begin
        started = 1;
        checks++; if (waddr !== ADDR_W'(got + 1) || wdata !== vals[got]) begin failures++; $display("FAIL fill_order got=%0d/%h exp=%0d/%h", waddr, wdata, got + 1, vals[got]); end
        got++;
      end else if (started) begin
        checks++; failures++; $display("FAIL fill_gap got=0 exp=1 after %0d writes", got);
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (got != 6) begin failures++; $display("FAIL fill_timeout got=%0d writes exp=6", got); end
  endtask

  task automatic test_random(input int n_push, input bit allow_r0);
    logic hit;
    logic [DATA_W-1:0] d;
    int pushed = 0, cyc = 0;
    while ((pushed < n_push || mq_addr.size() > 0 || m_we) && cyc < 400) begin
      in_valid = (pushed < n_push) && ($urandom_range(0, 2) != 0);
      in_addr = allow_r0 ? ADDR_W'($urandom_range(0, 31)) : ADDR_W'($urandom_range(1, 31));
      in_data = $urandom;
      fw_raddr1 = ($urandom_range(0, 1) == 0 && mq_addr.size() > 0) ? mq_addr[0] : ADDR_W'($urandom_range(0, 31));
      fw_raddr2 = ADDR_W'($urandom_range(0, 31));
      #1;
      checks++; if (in_ready !== (mq_addr.size() < DEPTH)) begin failures++; $display("FAIL rnd_ready got=%0b exp=%0b", in_ready, mq_addr.size() < DEPTH); end
      model_fw(fw_raddr1, hit, d);
      checks++; if (fw_hit1 !== hit || fw_data1 !== d) begin failures++; $display("FAIL rnd_fw1 ra=%0d got=%0b/%h exp=%0b/%h", fw_raddr1, fw_hit1, fw_data1, hit, d); end
      model_fw(fw_raddr2, hit, d);
      checks++; if (fw_hit2 !== hit || fw_data2 !== d) begin failures++; $display("FAIL rnd_fw2 ra=%0d got=%0b/%h exp=%0b/%h", fw_raddr2, fw_hit2, fw_data2, hit, d); end
      tick();
      if (last_acc) pushed++;
      checks++; if (we !== m_we) begin failures++; $display("FAIL rnd_we got=%0b exp=%0b", we, m_we); end
      if (m_we) begin
        checks++; if (waddr !== m_waddr || wdata !== m_wdata) begin failures++; $display("FAIL rnd_write got=%0d/%h exp=%0d/%h", waddr, wdata, m_waddr, m_wdata); end
      end
      checks++; if (count !== CNT_W'(mq_addr.size()) || idle !== (mq_addr.size() == 0 && !m_we)) begin failures++; $display("FAIL rnd_count got=%0d/%0b exp=%0d", count, idle, mq_addr.size()); end
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (pushed != n_push || mq_addr.size() != 0) begin failures++; $display("FAIL rnd_timeout pushed=%0d exp=%0d", pushed, n_push); end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_addr = 5'd12; in_data = 32'hA5A5_0001;
    tick();
    in_addr = 5'd13; in_data = 32'hA5A5_0002;
    tick();
    in_valid = 1'b0;
    fw_raddr1 = 5'd13;
    fw_raddr2 = 5'd12;
    @(negedge clk);
    #2;
    model_reset();
    #1;
    checks++; if (we !== 1'b0 || count !== '0 || waddr !== '0 || wdata !== '0) begin failures++; $display("FAIL arst_regs we=%0b count=%0d waddr=%0d exp=0/0/0", we, count, waddr); end
    checks++; if (fw_hit1 !== 1'b0 || fw_hit2 !== 1'b0 || fw_data1 !== '0) begin failures++; $display("FAIL arst_fw got=%0b/%0b exp=0/0", fw_hit1, fw_hit2); end
    checks++; if (in_ready !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL arst_ready ready=%0b idle=%0b exp=0/1", in_ready, idle); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (we !== 1'b0 || count !== '0) begin failures++; $display("FAIL arst_stale cycle=%0d we=%0b count=%0d exp=0/0", i, we, count); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_r0();
    test_forward();
    test_fill();
    test_random(3 * DEPTH + 1, 1'b0);
    test_random(60, 1'b1);
    test_async_reset();
    test_random(20, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
